// File: rtl/alu_mdu.sv
// alu_mdu: handshaked ALU with RV32M multiply/divide (iterative shift-add / restoring divide).
// Define ALU_MDU_FASTMUL_EN to compute multiplies combinationally in a single cycle.
module alu_mdu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal_op,
  output logic            busy
);
  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned DW  = 2 * XLEN;

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND    = 5'd2,  OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4,  OP_SLL  = 5'd5,  OP_SRL    = 5'd6,  OP_SRA   = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8,  OP_SLTU = 5'd9,  OP_MUL    = 5'd10, OP_MULH  = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14, OP_DIVU  = 5'd15;
  localparam logic [4:0] OP_REM  = 5'd16, OP_REMU = 5'd17;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e          state_q;
  logic [XLEN-1:0] result_q, opb_q;
  logic [DW-1:0]   acc_q;
  logic [SHW-1:0]  cnt_q;
  logic [4:0]      op_q;
  logic            out_valid_q, zero_q, illegal_q, busy_q, in_ready_q, neg_q_q, neg_r_q;

  // Signed results are formed by negating the unsigned magnitude product.
  function automatic logic [XLEN-1:0] mul_pick(input logic [DW-1:0] mag, input logic neg,
                                               input logic lo);
    logic [DW-1:0] p;
    p = neg ? (~mag + DW'(1)) : mag;
    return lo ? p[XLEN-1:0] : p[DW-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] div_pick(input logic [XLEN-1:0] q, input logic [XLEN-1:0] r,
                                               input logic neg_q, input logic neg_r, input logic quo);
    logic [XLEN-1:0] qs, rs;
    qs = neg_q ? (~q + XLEN'(1)) : q;
    rs = neg_r ? (~r + XLEN'(1)) : r;
    return quo ? qs : rs;
  endfunction

  logic            a_sgn_c, b_sgn_c, a_neg_c, b_neg_c, ovf_c, go_mul_c, go_div_c, ill_c;
  logic [XLEN-1:0] a_mag_c, b_mag_c, alu_c, imm_c;
  logic [SHW-1:0]  shamt_c;

  // Operand decode and everything that completes on the accept edge.
  always_comb begin
    a_sgn_c  = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_sgn_c  = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg_c  = a_sgn_c & src_a[XLEN-1];
    b_neg_c  = b_sgn_c & src_b[XLEN-1];
    a_mag_c  = a_neg_c ? (~src_a + XLEN'(1)) : src_a;
    b_mag_c  = b_neg_c ? (~src_b + XLEN'(1)) : src_b;
    ovf_c    = ((op == OP_DIV) || (op == OP_REM)) && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
    shamt_c  = src_b[SHW-1:0];
    case (op)
      OP_ADD:  alu_c = src_a + src_b;
      OP_SUB:  alu_c = src_a - src_b;
      OP_AND:  alu_c = src_a & src_b;
      OP_OR:   alu_c = src_a | src_b;
      OP_XOR:  alu_c = src_a ^ src_b;
      OP_SLL:  alu_c = src_a << shamt_c;
      OP_SRL:  alu_c = src_a >> shamt_c;
      OP_SRA:  alu_c = XLEN'($signed(src_a) >>> shamt_c);
      OP_SLT:  alu_c = XLEN'($signed(src_a) < $signed(src_b));
      OP_SLTU: alu_c = XLEN'(src_a < src_b);
      default: alu_c = '0;
    endcase
    imm_c    = alu_c;
    go_mul_c = 1'b0;
    go_div_c = 1'b0;
    ill_c    = 1'b0;
    if (op <= OP_SLTU) begin
      imm_c = alu_c;
    end else if (op <= OP_MULHU) begin
`ifdef ALU_MDU_FASTMUL_EN
      imm_c = mul_pick(DW'(a_mag_c) * DW'(b_mag_c), a_neg_c ^ b_neg_c, op == OP_MUL);
`else
      go_mul_c = 1'b1;
`endif
    end else if (op <= OP_REMU) begin
      if (src_b == '0)
        imm_c = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : src_a;
      else if (ovf_c)
        imm_c = (op == OP_DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
      else
        go_div_c = 1'b1;
    end else begin
      imm_c = '0;
      ill_c = 1'b1;
    end
  end

  logic [XLEN:0]   mul_sum_c, div_sh_c, div_diff_c;
  logic [DW-1:0]   mul_nxt_c, div_nxt_c;
  logic [XLEN-1:0] fin_c;

  // One iteration step; acc holds {hi, lo} for MUL and {remainder, dividend/quotient} for DIV.
  always_comb begin
    mul_sum_c  = {1'b0, acc_q[DW-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_nxt_c  = {mul_sum_c, acc_q[XLEN-1:1]};
    div_sh_c   = {acc_q[DW-1:XLEN], acc_q[XLEN-1]};
    div_diff_c = div_sh_c - {1'b0, opb_q};
    div_nxt_c  = {(div_diff_c[XLEN] ? div_sh_c[XLEN-1:0] : div_diff_c[XLEN-1:0]),
                  acc_q[XLEN-2:0], ~div_diff_c[XLEN]};
    fin_c      = (state_q == S_MUL) ? mul_pick(mul_nxt_c, neg_q_q, op_q == OP_MUL)
               : div_pick(div_nxt_c[XLEN-1:0], div_nxt_c[DW-1:XLEN], neg_q_q, neg_r_q,
                          (op_q == OP_DIV) || (op_q == OP_DIVU));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      cnt_q       <= '0;
      op_q        <= '0;
      acc_q       <= '0;
      opb_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          in_ready_q <= 1'b0;
          op_q       <= op;
          neg_q_q    <= a_neg_c ^ b_neg_c;
          neg_r_q    <= a_neg_c;
          cnt_q      <= '0;
          illegal_q  <= ill_c;
          if (go_mul_c) begin
            acc_q   <= {XLEN'(0), b_mag_c};
            opb_q   <= a_mag_c;
            busy_q  <= 1'b1;
            state_q <= S_MUL;
          end else if (go_div_c) begin
            acc_q   <= {XLEN'(0), a_mag_c};
            opb_q   <= b_mag_c;
            busy_q  <= 1'b1;
            state_q <= S_DIV;
          end else begin
            result_q    <= imm_c;
            zero_q      <= (imm_c == '0);
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_MUL, S_DIV: begin
          acc_q <= (state_q == S_MUL) ? mul_nxt_c : div_nxt_c;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == SHW'(XLEN-1)) begin
            result_q    <= fin_c;
            zero_q      <= (fin_c == '0);
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_DONE;
          end
        end
        S_DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign zero       = zero_q;
  assign illegal_op = illegal_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: ALU ops, multiply, divide corner cases, backpressure, reset, illegal ops.
module tb_alu_mdu;
`ifdef ALU_MDU_FASTMUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready, zero, illegal_op, busy;
  logic [4:0]  op;
  logic [31:0] src_a, src_b, result;
  int          checks, errors;

  alu_mdu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal_op(illegal_op), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Issue one op, wait (bounded) for out_valid, capture outputs, then complete the handshake.
  task automatic do_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output logic z, output logic il);
    @(negedge clk);
    in_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    res = result; z = zero; il = illegal_op;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
    checks++; if ({busy, zero, illegal_op} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, zero, illegal_op}); end
  endtask

  task automatic test_alu;
    logic [4:0]  to [11] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd0};
    logic [31:0] ta [11] = '{32'hFFFFFFFF, 32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'd1,
                             32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF};
    logic [31:0] tb [11] = '{32'd1, 32'd7, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'h1F,
                             32'h24, 32'h24, 32'd1, 32'd1, 32'd1};
    logic [31:0] te [11] = '{32'h0, 32'hFFFFFFFE, 32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'h80000000,
                             32'h08000000, 32'hF8000000, 32'd1, 32'd0, 32'h80000000};
    logic [31:0] res;
    int          lat;
    logic        z, il;
    for (int i = 0; i < 11; i++) begin
      do_op(to[i], ta[i], tb[i], res, lat, z, il);
      checks++; if (res !== te[i]) begin errors++; $display("FAIL alu_result[%0d] op %0d got %h exp %h", i, to[i], res, te[i]); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL alu_latency[%0d] got %0d exp 1", i, lat); end
      checks++; if (z !== (te[i] == 32'h0)) begin errors++; $display("FAIL alu_zero[%0d] got %b exp %b", i, z, te[i] == 32'h0); end
    end
  endtask

  task automatic test_mul;
    logic [4:0]  to [5] = '{5'd11, 5'd10, 5'd13, 5'd12, 5'd10};
    logic [31:0] ta [5] = '{32'h80000000, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    logic [31:0] tb [5] = '{32'h80000000, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2, 32'd5};
    logic [31:0] te [5] = '{32'h40000000, 32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0};
    logic [31:0] res;
    int          lat;
    logic        z, il;
    for (int i = 0; i < 5; i++) begin
      do_op(to[i], ta[i], tb[i], res, lat, z, il);
      checks++; if (res !== te[i]) begin errors++; $display("FAIL mul_result[%0d] op %0d got %h exp %h", i, to[i], res, te[i]); end
      checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL mul_latency[%0d] got %0d exp %0d", i, lat, MUL_LAT); end
    end
  endtask

  task automatic test_div;
    logic [4:0]  to [12] = '{5'd14, 5'd16, 5'd15, 5'd17, 5'd14, 5'd14, 5'd16, 5'd15, 5'd17, 5'd14, 5'd16, 5'd14};
    logic [31:0] ta [12] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'd5, 32'd0, 32'h80000000, 32'h80000000,
                             32'd100, 32'd100, 32'd7, 32'd7, 32'h80000000};
    logic [31:0] tb [12] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd3};
    logic [31:0] te [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h80000000, 32'h0,
                             32'd14, 32'd2, 32'hFFFFFFFD, 32'd1, 32'hD5555556};
    int          tl [12] = '{33, 33, 1, 1, 1, 1, 1, 33, 33, 33, 33, 33};
    logic [31:0] res;
    int          lat;
    logic        z, il;
    for (int i = 0; i < 12; i++) begin
      do_op(to[i], ta[i], tb[i], res, lat, z, il);
      checks++; if (res !== te[i]) begin errors++; $display("FAIL div_result[%0d] op %0d got %h exp %h", i, to[i], res, te[i]); end
      checks++; if (lat !== tl[i]) begin errors++; $display("FAIL div_latency[%0d] got %0d exp %0d", i, lat, tl[i]); end
      checks++; if (z !== (te[i] == 32'h0)) begin errors++; $display("FAIL div_zero[%0d] got %b exp %b", i, z, te[i] == 32'h0); end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] res;
    int          lat;
    logic        z, il;
    @(negedge clk);
    in_valid = 1'b1; op = 5'd0; src_a = 32'd3; src_b = 32'd4;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid got %b exp 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 5'd0; src_a = 32'd1; src_b = 32'd1;
      checks++; if (result !== 32'd7) begin errors++; $display("FAIL bp_hold_result[%0d] got %h exp 7", i, result); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got %b exp 1", i, out_valid); end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL bp_release got %b exp 10", {in_ready, out_valid}); end
    do_op(5'd0, 32'd1, 32'd1, res, lat, z, il);
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL bp_next_op got %h exp 2", res); end
  endtask

  task automatic test_reset_mid_div;
    int seen;
    @(negedge clk);
    in_valid = 1'b1; op = 5'd15; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before got %b exp 1", busy); end
    @(negedge clk); rst = 1'b1;
    #1;
    checks++; if ({busy, out_valid, in_ready} !== 3'b001) begin errors++; $display("FAIL rst_mid_state got %b exp 001", {busy, out_valid, in_ready}); end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_valid got %0d exp 0", seen); end
  endtask

  task automatic test_illegal;
    logic [31:0] res;
    int          lat;
    logic        z, il;
    do_op(5'd20, 32'h1234, 32'h5678, res, lat, z, il);
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL ill_result got %h exp 0", res); end
    checks++; if ({il, z} !== 2'b11) begin errors++; $display("FAIL ill_flags got %b exp 11", {il, z}); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL ill_latency got %0d exp 1", lat); end
    checks++; if (illegal_op !== 1'b1) begin errors++; $display("FAIL ill_held got %b exp 1", illegal_op); end
    do_op(5'd0, 32'd2, 32'd3, res, lat, z, il);
    checks++; if ({il, res} !== {1'b0, 32'd5}) begin errors++; $display("FAIL ill_cleared got %b/%h exp 0/5", il, res); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_alu;
    test_mul;
    test_div;
    test_backpressure;
    test_reset_mid_div;
    test_illegal;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
Parametrised, handshaked successor to the single-cycle ALU.
- Covers the existing base ops, adds SLT/SLTU and the RV32M multiply/divide ops.
- Single-cycle ops complete in 1 cycle; multiply and divide run iteratively over XLEN cycles.
- Sits between decode/operand-read and writeback; a valid/ready handshake lets the pipeline stall while the block is busy.

Parameters:
XLEN, 32, datapath width; power of 2, >= 8.
SHW, $clog2(XLEN), shift-amount width; derived, not overridden.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  operand/op presented
in_ready  out  1  block can accept an op
op  in  5  operation code (see Behaviour)
src_a  in  XLEN  operand A
src_b  in  XLEN  operand B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  XLEN  registered result
zero  out  1  result == 0; valid with out_valid
illegal_op  out  1  op code undefined; valid with out_valid
busy  out  1  iterative operation in progress

Behaviour:
- Op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA (shift amount = src_b[SHW-1:0])
  - 8 SLT, 9 SLTU: result = {XLEN-1 zeros, cmp}
  - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU
  - 14 DIV, 15 DIVU, 16 REM, 17 REMU
  - 18..31 illegal.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN. MUL returns the low XLEN bits of the 2*XLEN product; MULH* return the high XLEN bits with the RISC-V signedness.
- FSM states IDLE, MUL, DIV, DONE. Reset: state=IDLE, result=0, out_valid=0, zero=0, illegal_op=0, busy=0, counter=0.
- in_ready = (state==IDLE). An op is accepted when in_valid & in_ready.
- Single-cycle ops (0-9):
  - IDLE -> DONE.
  - result registered on the accept edge; out_valid high the next cycle (latency 1).
- Illegal op:
  - IDLE -> DONE with result=0, illegal_op=1, zero=1.
  - illegal_op is cleared when the next op is accepted.
- MUL ops (10-13):
  - IDLE -> MUL. Operands latched, sign-extended or zero-extended per op.
  - Shift-add runs for exactly XLEN cycles with busy=1, then MUL -> DONE.
  - out_valid asserts XLEN+1 cycles after accept.
- DIV ops (14-17):
  - IDLE -> DIV. Restoring divide on the magnitudes runs for XLEN cycles with busy=1; signs are fixed up on exit to DONE.
  - Quotient sign = sign(a)^sign(b). Remainder takes the sign of the dividend.
  - Divide by zero: no iteration; DONE next cycle. Quotient = all ones, remainder = src_a.
  - Signed overflow (most-negative / -1): no iteration; DONE next cycle. Quotient = most-negative, remainder = 0.
- DONE:
  - out_valid=1; result, zero and illegal_op held stable until out_ready.
  - out_valid & out_ready -> IDLE. in_ready rises the following cycle, so there is no accept in the same cycle as the output handshake.
  - out_ready held low: stay in DONE indefinitely.
- in_valid while not in IDLE: ignored; the op is not consumed.
- zero: computed from the final result, registered together with it.
- rst asserted at any time (including mid-MUL/DIV): immediate return to reset values. The partial operation is discarded and no out_valid is produced for it.

Optional Feature:
Macro ALU_MDU_FASTMUL_EN.
- Defined: MUL ops are computed with a combinational XLEN x XLEN multiply. The MUL state is unused; MUL ops behave as single-cycle ops (latency 1, busy never set for multiplies).
- Undefined: iterative multiplier as above (latency XLEN+1). Divide behaviour is identical in both builds.

Test Plan:
- After reset: out_valid=0, in_ready=1, result=0. Op ADD, a=0xFFFFFFFF, b=1 -> 1 cycle later out_valid=1, result=0, zero=1.
- SRA a=0x80000000, b=0x24 (shift 4) -> 0xF8000000. SLT a=-1, b=1 -> 1. SLTU a=-1, b=1 -> 0.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000, out_valid exactly 33 cycles after accept (1 with ALU_MDU_FASTMUL_EN). MUL 7*-3 -> 0xFFFFFFEB.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF. DIVU x/0 -> 0xFFFFFFFF in 1 cycle. DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0.
- Backpressure: out_ready=0 for 5 cycles after a result -> result stable, in_ready=0, new in_valid ignored. Release -> returns to IDLE, next op accepted.
- Assert rst at cycle 10 of a DIVU -> state IDLE, busy=0, no out_valid. Op 20 after reset -> illegal_op=1, result=0.
